// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the eight-entry register bank.
// Register count, index width and data width live here so the decoder and the bank agree.
package reg_bank_pkg;

    localparam int NREGS  = 8;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 16;

    typedef logic [IDX_W-1:0] reg_idx_t;
    typedef logic [NREGS-1:0] onehot_t;

endpackage : reg_bank_pkg

// File: rtl/dec3to8.sv
// 3-bit register index to 8-bit one-hot select.
// Every input code is legal, so the output always has exactly one bit set.
module dec3to8
    import reg_bank_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [NREGS-1:0] onehot
);

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
        assign onehot[gi] = (idx == IDX_W'(gi));
    end

endmodule : dec3to8

// File: rtl/reg_bank8.sv
// Eight 16-bit registers fed through a one-entry staging buffer with a hold input,
// plus the one-hot read-select decode for the downstream 8-to-1 multiplexer.
module reg_bank8 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_valid,
    input  logic [2:0]        write_num,
    input  logic [DATA_W-1:0] data_in,
    output logic              write_ready,
    input  logic              hold,
    input  logic [2:0]        read_num,
    output logic [7:0]        decoded_read_num,
    output logic [DATA_W-1:0] R0,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    output logic [DATA_W-1:0] R3,
    output logic [DATA_W-1:0] R4,
    output logic [DATA_W-1:0] R5,
    output logic [DATA_W-1:0] R6,
    output logic [DATA_W-1:0] R7,
    output logic [7:0]        reg_valid,
    output logic              write_pending
);

    import reg_bank_pkg::NREGS;
    import reg_bank_pkg::reg_idx_t;
    import reg_bank_pkg::onehot_t;

    logic              stg_full_reg;
    reg_idx_t          stg_num_reg;
    logic [DATA_W-1:0] stg_data_reg;

    logic [DATA_W-1:0] regs_reg [NREGS];
    onehot_t           reg_valid_reg;

    onehot_t           stg_onehot;
    onehot_t           load_en;
    logic              accept;
    logic              commit;

    // A full buffer that is draining this cycle can still take a new write.
    assign write_ready   = !stg_full_reg || !hold;
    assign accept        = write_valid && write_ready;
    assign commit        = stg_full_reg && !hold;
    assign write_pending = stg_full_reg;

    dec3to8 u_write_dec (
        .idx    (stg_num_reg),
        .onehot (stg_onehot)
    );

    dec3to8 u_read_dec (
        .idx    (read_num),
        .onehot (decoded_read_num)
    );

    assign load_en = stg_onehot & {NREGS{commit}};

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_full_reg <= 1'b0;
            stg_num_reg  <= '0;
            stg_data_reg <= '0;
        end else if (accept) begin
            // Reloading on the commit edge keeps the buffer full for back-to-back writes.
            stg_full_reg <= 1'b1;
            stg_num_reg  <= write_num;
            stg_data_reg <= data_in;
        end else if (commit) begin
            stg_full_reg <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
        always_ff @(posedge clk) begin
            if (reset) begin
                regs_reg[gi]      <= '0;
                reg_valid_reg[gi] <= 1'b0;
            end else if (load_en[gi]) begin
                regs_reg[gi]      <= stg_data_reg;
                reg_valid_reg[gi] <= 1'b1;
            end
        end
    end

    assign reg_valid = reg_valid_reg;

    assign R0 = regs_reg[0];
    assign R1 = regs_reg[1];
    assign R2 = regs_reg[2];
    assign R3 = regs_reg[3];
    assign R4 = regs_reg[4];
    assign R5 = regs_reg[5];
    assign R6 = regs_reg[6];
    assign R7 = regs_reg[7];

endmodule : reg_bank8

// File: tb/tb_reg_bank8.sv
// Randomized self-checking bench for reg_bank8 against a transaction-level model:
// a pending-write slot plus an array of register values and written flags.
module tb_reg_bank8;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_valid;
    logic [2:0]  write_num;
    logic [15:0] data_in;
    logic        write_ready;
    logic        hold;
    logic [2:0]  read_num;
    logic [7:0]  decoded_read_num;
    logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;
    logic [7:0]  reg_valid;
    logic        write_pending;

    always #5 clk = ~clk;

    reg_bank8 #(.DATA_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .write_valid      (write_valid),
        .write_num        (write_num),
        .data_in          (data_in),
        .write_ready      (write_ready),
        .hold             (hold),
        .read_num         (read_num),
        .decoded_read_num (decoded_read_num),
        .R0               (R0),
        .R1               (R1),
        .R2               (R2),
        .R3               (R3),
        .R4               (R4),
        .R5               (R5),
        .R6               (R6),
        .R7               (R7),
        .reg_valid        (reg_valid),
        .write_pending    (write_pending)
    );

    logic [15:0] r_obs [8];
    assign r_obs[0] = R0;
    assign r_obs[1] = R1;
    assign r_obs[2] = R2;
    assign r_obs[3] = R3;
    assign r_obs[4] = R4;
    assign r_obs[5] = R5;
    assign r_obs[6] = R6;
    assign r_obs[7] = R7;

    // Reference model: committed contents, written flags, and one pending write.
    logic [15:0] m_regs [8];
    logic [7:0]  m_written;
    logic        m_pend;
    logic [2:0]  m_pnum;
    logic [15:0] m_pdata;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_written = 8'h00;
        m_pend    = 1'b0;
        m_pnum    = 3'd0;
        m_pdata   = 16'h0000;
    endtask

    // One clock cycle: drive inputs, check combinational outputs, clock, check state.
    task automatic step(input logic rst, input logic wv, input logic [2:0] wn,
                        input logic [15:0] d, input logic h, input logic [2:0] rn,
                        output logic accepted);
        logic m_ready;
        reset       = rst;
        write_valid = wv;
        write_num   = wn;
        data_in     = d;
        hold        = h;
        read_num    = rn;
        #1;
        m_ready = !m_pend || !h;
        check("write_ready", 32'(write_ready), 32'(m_ready));
        check("decoded_read_num", 32'(decoded_read_num), 32'(8'd1 << rn));
        @(posedge clk);
        accepted = !rst && wv && m_ready;
        if (rst) begin
            model_clear();
        end else begin
            if (m_pend && !h) begin
                m_regs[m_pnum]    = m_pdata;
                m_written[m_pnum] = 1'b1;
                m_pend            = 1'b0;
            end
            if (accepted) begin
                m_pend  = 1'b1;
                m_pnum  = wn;
                m_pdata = d;
                $display("write R%0d <= %h (hold=%0b) t=%0t", wn, d, h, $time);
            end
        end
        #1;
        for (int i = 0; i < 8; i++) check($sformatf("R%0d", i), 32'(r_obs[i]), 32'(m_regs[i]));
        check("reg_valid", 32'(reg_valid), 32'(m_written));
        check("write_pending", 32'(write_pending), 32'(m_pend));
    endtask

    task automatic do_reset();
        logic acc;
        step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, acc);
    endtask

    initial begin
        logic        acc;
        logic        have_offer;
        logic [2:0]  off_num;
        logic [15:0] off_data;
        logic        r_rst, r_hold;

        reset = 1'b1; write_valid = 1'b0; write_num = 3'd0; data_in = 16'h0;
        hold = 1'b0; read_num = 3'd0;
        @(posedge clk);
        #1;
        model_clear();

        // Reset held while sweeping every read index.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'(i), acc);
        check("reset_reg_valid", 32'(reg_valid), 32'h00);

        // Single write: pending after edge k, visible after k+1.
        step(1'b0, 1'b1, 3'd3, 16'hABCD, 1'b0, 3'd3, acc);
        check("abcd_accepted", 32'(acc), 32'd1);
        check("abcd_pending_k", 32'(write_pending), 32'd1);
        check("abcd_r3_old_k", 32'(R3), 32'h0000);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd3, acc);
        check("abcd_r3_k1", 32'(R3), 32'hABCD);
        check("abcd_valid_k1", 32'(reg_valid), 32'h08);

        // Back-to-back writes, same register twice; last value wins.
        do_reset();
        step(1'b0, 1'b1, 3'd0, 16'h0001, 1'b0, 3'd0, acc);
        step(1'b0, 1'b1, 3'd7, 16'h0002, 1'b0, 3'd7, acc);
        step(1'b0, 1'b1, 3'd0, 16'h0003, 1'b0, 3'd0, acc);
        check("b2b_third_accepted", 32'(acc), 32'd1);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, acc);
        check("b2b_r0", 32'(R0), 32'h0003);
        check("b2b_r7", 32'(R7), 32'h0002);
        check("b2b_valid", 32'(reg_valid), 32'h81);

        // Hold: one write accepted, second stalls until release.
        do_reset();
        step(1'b0, 1'b1, 3'd1, 16'h1111, 1'b1, 3'd1, acc);
        check("hold_first_acc", 32'(acc), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 3'd2, 16'h2222, 1'b1, 3'd1, acc);
            check("hold_second_blocked", 32'(acc), 32'd0);
            check("hold_r1_frozen", 32'(R1), 32'h0000);
        end
        step(1'b0, 1'b1, 3'd2, 16'h2222, 1'b0, 3'd2, acc);
        check("release_second_acc", 32'(acc), 32'd1);
        check("release_r1", 32'(R1), 32'h1111);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd2, acc);
        check("release_r2", 32'(R2), 32'h2222);

        // Reset discards a staged write.
        do_reset();
        step(1'b0, 1'b1, 3'd5, 16'h5555, 1'b1, 3'd5, acc);
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, acc);
        check("rst_r5", 32'(R5), 32'h0000);
        check("rst_pending", 32'(write_pending), 32'd0);
        check("rst_valid", 32'(reg_valid), 32'h00);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, acc);
        check("rst_ready_held", 32'(write_ready), 32'd1);

        // Random traffic; requester keeps its offer stable until accepted.
        have_offer = 1'b0;
        off_num    = 3'd0;
        off_data   = 16'h0;
        for (int c = 0; c < 600; c++) begin
            if (!have_offer && ($urandom_range(0, 3) != 0)) begin
                have_offer = 1'b1;
                off_num    = 3'($urandom_range(0, 7));
                off_data   = 16'($urandom);
            end
            r_rst  = ($urandom_range(0, 99) == 0);
            r_hold = ($urandom_range(0, 9) < 3);
            step(r_rst, have_offer, off_num, off_data, r_hold, 3'($urandom_range(0, 7)), acc);
            if (acc) have_offer = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reg_bank8
